// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the packet sources and the arbiter, and between the arbiter and uart_tx.
// The arbiter takes the master modport. Testbenches and producers take the slave modport.
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8
);
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ-1:0]            req_last;
   logic [NUM_REQ-1:0]            req_ready;
   logic [DATA_WIDTH-1:0]         tx_data;
   logic                          tx_valid;
   logic                          tx_ready;

   modport master (
      input  req_data, req_valid, req_last, tx_ready,
      output req_ready, tx_data, tx_valid
   );

   modport slave (
      output req_data, req_valid, req_last, tx_ready,
      input  req_ready, tx_data, tx_valid
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter in front of a single uart_tx. The grant is locked for one packet.
// Each packet is sent as a header word carrying the source ID, followed by its payload.
module uart_tx_arbiter #(
   parameter int                    NUM_REQ     = 4,
   parameter int                    DATA_WIDTH  = 8,
   parameter int                    MAX_PKT_LEN = 64,
   parameter logic [DATA_WIDTH-1:0] HDR_MARK    = 8'hA0,
   localparam int                   ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic              clk,
   input  logic              rstn,
   uart_tx_arbiter_if.master bus,
   output logic [ID_W-1:0]   grant_id,
   output logic              busy,
   output logic              pkt_overrun
);
   localparam int          CNT_W = $clog2(MAX_PKT_LEN + 1);
   localparam int unsigned N     = NUM_REQ;

   typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} state_t;

   state_t                state;
   logic [ID_W-1:0]       ptr;
   logic [ID_W-1:0]       winner;
   logic                  found;
   int unsigned           idx;
   logic [CNT_W-1:0]      beat_cnt;
   logic [CNT_W-1:0]      beat_nxt;
   logic                  can_load;
   logic                  sel_valid;
   logic                  sel_last;
   logic [DATA_WIDTH-1:0] sel_data;
   logic [DATA_WIDTH-1:0] hdr_word;

   assign can_load = !bus.tx_valid || bus.tx_ready;
   assign busy     = (state != IDLE);
   assign hdr_word = {HDR_MARK[DATA_WIDTH-1:ID_W], grant_id};
   assign beat_nxt = beat_cnt + 1'b1;

   // Search starts one past the last winner, so every requester gets a turn.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = 0;
      for (int unsigned k = 1; k <= N; k++) begin
         idx = (32'(ptr) + k) % N;
         for (int unsigned j = 0; j < N; j++) begin
            if (!found && idx == j && bus.req_valid[j]) begin
               found  = 1'b1;
               winner = ID_W'(j);
            end
         end
      end
   end

   always_comb begin
      sel_valid     = 1'b0;
      sel_last      = 1'b0;
      sel_data      = '0;
      bus.req_ready = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (grant_id == ID_W'(i)) begin
            sel_valid        = bus.req_valid[i];
            sel_last         = bus.req_last[i];
            sel_data         = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            bus.req_ready[i] = (state == PAYLOAD) && can_load;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state        <= IDLE;
         ptr          <= ID_W'(NUM_REQ - 1);
         grant_id     <= '0;
         beat_cnt     <= '0;
         bus.tx_valid <= 1'b0;
         bus.tx_data  <= '0;
         pkt_overrun  <= 1'b0;
      end else begin
         pkt_overrun <= 1'b0;
         if (bus.tx_ready) bus.tx_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (found) begin
                  grant_id <= winner;
                  ptr      <= winner;
                  beat_cnt <= '0;
                  state    <= HEADER;
               end
            end
            HEADER: begin
               if (can_load) begin
                  bus.tx_data  <= hdr_word;
                  bus.tx_valid <= 1'b1;
                  state        <= PAYLOAD;
               end
            end
            PAYLOAD: begin
               if (sel_valid && can_load) begin
                  bus.tx_data  <= sel_data;
                  bus.tx_valid <= 1'b1;
                  beat_cnt     <= beat_nxt;
                  if (sel_last) begin
                     state <= IDLE;
                  end else if (beat_nxt == CNT_W'(MAX_PKT_LEN)) begin
                     state       <= IDLE;
                     pkt_overrun <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (4 requesters, MAX_PKT_LEN=4).
// Per-requester beat FIFOs feed the DUT, and accepted tx words are logged for stream checks.
module tb_uart_tx_arbiter;
   logic       clk;
   logic       rstn;
   logic [1:0] grant_id;
   logic       busy;
   logic       pkt_overrun;

   uart_tx_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8)) bus ();

   uart_tx_arbiter #(
      .NUM_REQ    (4),
      .DATA_WIDTH (8),
      .MAX_PKT_LEN(4),
      .HDR_MARK   (8'hA0)
   ) dut (
      .clk        (clk),
      .rstn       (rstn),
      .bus        (bus),
      .grant_id   (grant_id),
      .busy       (busy),
      .pkt_overrun(pkt_overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         n_cmp;
   int         n_mis;
   int         ovr_cnt;
   logic [8:0] mem [4][32];
   int         head [4];
   int         tail [4];
   logic [3:0] hs;
   logic [7:0] txq [$];
   logic [7:0] exp_q [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_src();
      for (int i = 0; i < 4; i++) begin
         head[i] = 0;
         tail[i] = 0;
      end
   endtask

   task automatic push(input int id, input logic [7:0] data, input logic last);
      mem[id][tail[id]] = {last, data};
      tail[id]++;
   endtask

   task automatic drive();
      for (int i = 0; i < 4; i++) begin
         if (head[i] < tail[i]) begin
            bus.req_valid[i]        = 1'b1;
            bus.req_data[i*8 +: 8]  = mem[i][head[i]][7:0];
            bus.req_last[i]         = mem[i][head[i]][8];
         end else begin
            bus.req_valid[i]        = 1'b0;
            bus.req_data[i*8 +: 8]  = 8'h00;
            bus.req_last[i]         = 1'b0;
         end
      end
   endtask

   // Sample handshakes mid-cycle, cross the active edge, then update the sources.
   task automatic tick();
      @(negedge clk);
      hs = bus.req_valid & bus.req_ready;
      if (bus.tx_valid && bus.tx_ready) txq.push_back(bus.tx_data);
      if (pkt_overrun) ovr_cnt++;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) if (hs[i]) head[i]++;
      drive();
   endtask

   task automatic run_words(input string tag, input int n, input int budget);
      int c;
      c = 0;
      while (txq.size() < n && c < budget) begin
         tick();
         c++;
      end
      check({tag, "_words"}, txq.size(), n);
   endtask

   task automatic run_idle(input string tag, input int budget);
      int c;
      c = 0;
      while ((busy || bus.tx_valid) && c < budget) begin
         tick();
         c++;
      end
      check({tag, "_idle"}, {busy, bus.tx_valid}, 2'b00);
   endtask

   task automatic check_stream(input string tag);
      check({tag, "_len"}, txq.size(), exp_q.size());
      for (int k = 0; k < exp_q.size(); k++)
         check($sformatf("%s_w%0d", tag, k), (k < txq.size()) ? {24'h0, txq[k]} : 32'hDEAD, exp_q[k]);
      txq.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_cmp = 0;
      n_mis = 0;
      ovr_cnt = 0;
      clear_src();
      txq.delete();
      rstn = 1'b0;
      bus.tx_ready  = 1'b1;
      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.req_last  = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_tx_valid", bus.tx_valid, 0);
      check("rst_tx_data", bus.tx_data, 0);
      check("rst_req_ready", bus.req_ready, 0);
      check("rst_grant", grant_id, 0);
      check("rst_busy", busy, 0);
      check("rst_overrun", pkt_overrun, 0);
      rstn = 1'b1;

      // 1: single packet from req1, words back-to-back
      push(1, 8'h11, 0); push(1, 8'h22, 0); push(1, 8'h33, 1); drive();
      #1 check("t1_busy_pre", busy, 0);
      tick(); check("t1_busy", busy, 1); check("t1_grant", grant_id, 1); check("t1_txv0", bus.tx_valid, 0);
      tick(); check("t1_hdr", {bus.tx_valid, bus.tx_data}, 9'h1A1);
      tick(); check("t1_b1", {bus.tx_valid, bus.tx_data}, 9'h111);
      tick(); check("t1_b2", {bus.tx_valid, bus.tx_data}, 9'h122);
      tick(); check("t1_b3", {bus.tx_valid, bus.tx_data}, 9'h133); check("t1_busy_end", busy, 0);
      tick(); check("t1_txv_clr", bus.tx_valid, 0);
      txq.delete();

      // 2: req0 and req2 alternate; pointer sits at 1, so req2 goes first
      push(0, 8'h01, 1); push(0, 8'h02, 1); push(0, 8'h03, 1);
      push(2, 8'h21, 1); push(2, 8'h22, 1); push(2, 8'h23, 1); drive();
      run_words("t2", 12, 80);
      run_idle("t2", 20);
      exp_q = '{8'hA2, 8'h21, 8'hA0, 8'h01, 8'hA2, 8'h22, 8'hA0, 8'h02, 8'hA2, 8'h23, 8'hA0, 8'h03};
      check_stream("t2");

      // 3: backpressure mid-packet; 4 beats with last on beat 4 is not an overrun
      ovr_cnt = 0;
      push(1, 8'h51, 0); push(1, 8'h52, 0); push(1, 8'h53, 0); push(1, 8'h54, 1); drive();
      tick(); tick(); tick();
      check("t3_first", bus.tx_data, 8'h51);
      bus.tx_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("t3_hold_%0d", i), {bus.tx_valid, bus.tx_data, bus.req_ready}, {1'b1, 8'h51, 4'h0});
      end
      bus.tx_ready = 1'b1;
      run_words("t3", 5, 40);
      run_idle("t3", 20);
      exp_q = '{8'hA1, 8'h51, 8'h52, 8'h53, 8'h54};
      check_stream("t3");
      check("t3_no_ovr", ovr_cnt, 0);

      // 4: 6-beat packet from req3 is split after beat 4
      push(3, 8'h61, 0); push(3, 8'h62, 0); push(3, 8'h63, 0);
      push(3, 8'h64, 0); push(3, 8'h65, 0); push(3, 8'h66, 1); drive();
      run_words("t4", 8, 60);
      run_idle("t4", 20);
      exp_q = '{8'hA3, 8'h61, 8'h62, 8'h63, 8'h64, 8'hA3, 8'h65, 8'h66};
      check_stream("t4");
      check("t4_ovr", ovr_cnt, 1);
      check("t4_grant", grant_id, 3);

      // 5: reset after header + 1 beat, then req0 wins first
      push(2, 8'h71, 0); push(2, 8'h72, 0); push(2, 8'h73, 1); drive();
      tick(); tick(); tick();
      check("t5_pre", {busy, bus.tx_data}, {1'b1, 8'h71});
      rstn = 1'b0;
      #1;
      check("t5_rst_out", {bus.tx_valid, bus.tx_data, bus.req_ready, grant_id, busy, pkt_overrun}, 17'h0);
      clear_src(); drive();
      tick(); tick();
      txq.delete();
      rstn = 1'b1;
      push(0, 8'h81, 1); push(2, 8'h82, 1); drive();
      run_words("t5", 4, 40);
      run_idle("t5", 20);
      exp_q = '{8'hA0, 8'h81, 8'hA2, 8'h82};
      check_stream("t5");

      // 6: req1 asserts during req0's packet and must wait for its last beat
      ovr_cnt = 0;
      push(0, 8'h91, 0); push(0, 8'h92, 0); push(0, 8'h93, 0); push(0, 8'h94, 1); drive();
      tick();
      push(1, 8'hB1, 1); drive();
      tick();
      check("t6_lock", {busy, grant_id}, {1'b1, 2'd0});
      run_words("t6", 7, 60);
      run_idle("t6", 20);
      exp_q = '{8'hA0, 8'h91, 8'h92, 8'h93, 8'h94, 8'hA1, 8'hB1};
      check_stream("t6");
      check("t6_no_ovr", ovr_cnt, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
